// File: rtl/regfile_mp_pkg.sv
// Shared defaults and clear-FSM encoding for the multi-port register file.
package regfile_mp_pkg;

    localparam int unsigned RF_BW_DATA  = 16;
    localparam int unsigned RF_BW_ADDR  = 4;
    localparam int unsigned RF_NUM_RD   = 2;
    localparam int unsigned RF_RD_LAT   = 0;
    localparam int unsigned RF_BYPASS   = 1;
    localparam int unsigned RF_ZERO_REG = 0;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read/clear bus of the register file; master drives requests, slave is the file.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int unsigned BW_DATA = RF_BW_DATA,
    parameter int unsigned BW_ADDR = RF_BW_ADDR,
    parameter int unsigned NUM_RD  = RF_NUM_RD
);
    localparam int unsigned NUM_BE = BW_DATA / 8;

    logic                        rf_wr_en;
    logic [BW_ADDR-1:0]          rf_wr_addr;
    logic [BW_DATA-1:0]          rf_wr_data;
    logic [NUM_BE-1:0]           rf_wr_be;
    logic [NUM_RD*BW_ADDR-1:0]   rf_rd_addr;
    logic [NUM_RD*BW_DATA-1:0]   rf_rd_data;
    logic                        rf_clr;
    logic                        rf_clr_busy;
    logic                        rf_wr_drop;

    modport master (
        output rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_be, rf_rd_addr, rf_clr,
        input  rf_rd_data, rf_clr_busy, rf_wr_drop
    );

    modport slave (
        input  rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_be, rf_rd_addr, rf_clr,
        output rf_rd_data, rf_clr_busy, rf_wr_drop
    );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// One read lane: array mux, optional write-first bypass, zero-register mask,
// optional output register.
module regfile_mp_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int unsigned BW_DATA  = RF_BW_DATA,
    parameter int unsigned BW_ADDR  = RF_BW_ADDR,
    parameter int unsigned RD_LAT   = RF_RD_LAT,
    parameter int unsigned BYPASS   = RF_BYPASS,
    parameter int unsigned ZERO_REG = RF_ZERO_REG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BW_DATA-1:0] mem [2**BW_ADDR],
    input  logic [BW_ADDR-1:0] rd_addr,
    input  logic               wr_acc,
    input  logic [BW_ADDR-1:0] wr_addr,
    input  logic [BW_DATA-1:0] wr_merged,
    output logic [BW_DATA-1:0] rd_data
);

    logic [BW_DATA-1:0] rd_word;

    // Select stored word, override with same-cycle merged write, then mask entry 0.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((BYPASS != 0) && wr_acc && (rd_addr == wr_addr)) begin
            rd_word = wr_merged;
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_word = '0;
        end
    end

    if (RD_LAT != 0) begin : g_reg
        logic [BW_DATA-1:0] rd_q;

        // Registered read: captures the selected word every cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_word;
            end
        end

        assign rd_data = rd_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst;
        assign rd_data        = rd_word;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enable writes and a sequential clear sweep.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned BW_DATA  = RF_BW_DATA,
    parameter int unsigned BW_ADDR  = RF_BW_ADDR,
    parameter int unsigned NUM_RD   = RF_NUM_RD,
    parameter int unsigned RD_LAT   = RF_RD_LAT,
    parameter int unsigned BYPASS   = RF_BYPASS,
    parameter int unsigned ZERO_REG = RF_ZERO_REG
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int unsigned DEPTH  = 2**BW_ADDR;
    localparam int unsigned NUM_BE = BW_DATA / 8;

    logic [BW_DATA-1:0] mem_q [DEPTH];
    rf_state_e          state_q, state_d;
    logic [BW_ADDR-1:0] cnt_q, cnt_d;
    logic               busy;
    logic               wr_acc;
    logic [BW_DATA-1:0] wr_merged;

    assign busy   = (state_q == RF_SWEEP);
    assign wr_acc = bus.rf_wr_en & ~busy
                  & ~((ZERO_REG != 0) && (bus.rf_wr_addr == '0));

    assign bus.rf_clr_busy = busy;
    assign bus.rf_wr_drop  = bus.rf_wr_en & busy;

    // Merge enabled byte lanes of the write data into the currently stored word.
    always_comb begin
        wr_merged = mem_q[bus.rf_wr_addr];
        for (int unsigned b = 0; b < NUM_BE; b++) begin
            if (bus.rf_wr_be[b]) begin
                wr_merged[8*b +: 8] = bus.rf_wr_data[8*b +: 8];
            end
        end
    end

    // Storage update: sweep clears one entry per cycle, otherwise accepted writes land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[BW_ADDR'(i)] <= '0;
            end
        end else if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[bus.rf_wr_addr] <= wr_merged;
        end
    end

    // Clear FSM state and sweep counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear FSM next state: start on clr in IDLE, leave after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_IDLE: begin
                if (bus.rf_clr) begin
                    state_d = RF_SWEEP;
                    cnt_d   = '0;
                end
            end
            RF_SWEEP: begin
                cnt_d = cnt_q + BW_ADDR'(1);
                if (cnt_q == BW_ADDR'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        regfile_mp_rd_port #(
            .BW_DATA  (BW_DATA),
            .BW_ADDR  (BW_ADDR),
            .RD_LAT   (RD_LAT),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk       (clk),
            .rst       (rst),
            .mem       (mem_q),
            .rd_addr   (bus.rf_rd_addr[p*BW_ADDR +: BW_ADDR]),
            .wr_acc    (wr_acc),
            .wr_addr   (bus.rf_wr_addr),
            .wr_merged (wr_merged),
            .rd_data   (bus.rf_rd_data[p*BW_DATA +: BW_DATA])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: five configurations (lat/bypass combos plus zero-register) share stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [7:0]  rd_addr;
    logic        clr;

    logic [31:0] rd_w   [5];
    logic        busy_w [5];
    logic        drop_w [5];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instances: 0 lat0/bypass, 1 lat1/bypass, 2 lat0/no-bypass, 3 lat1/no-bypass, 4 zero-reg.
    for (genvar g = 0; g < 5; g++) begin : g_dut
        regfile_mp_if #(.BW_DATA(16), .BW_ADDR(4), .NUM_RD(2)) bus ();

        assign bus.rf_wr_en   = wr_en;
        assign bus.rf_wr_addr = wr_addr;
        assign bus.rf_wr_data = wr_data;
        assign bus.rf_wr_be   = wr_be;
        assign bus.rf_rd_addr = rd_addr;
        assign bus.rf_clr     = clr;
        assign rd_w[g]        = bus.rf_rd_data;
        assign busy_w[g]      = bus.rf_clr_busy;
        assign drop_w[g]      = bus.rf_wr_drop;

        regfile_mp #(
            .BW_DATA  (16),
            .BW_ADDR  (4),
            .NUM_RD   (2),
            .RD_LAT   ((g == 1 || g == 3) ? 1 : 0),
            .BYPASS   ((g == 2 || g == 3) ? 0 : 1),
            .ZERO_REG ((g == 4) ? 1 : 0)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic logic [15:0] rdp(input int inst, input int port);
        return (port != 0) ? rd_w[inst][31:16] : rd_w[inst][15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int drop_err;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_addr = '0; clr = 1'b0;
        tick();
        tick();
        chk("rst_lat1_rd", 32'(rdp(1, 0)), 32'h0);
        chk("rst_busy", 32'(busy_w[0]), 32'h0);
        rst = 1'b0;
        tick();

        // Reset contents on both ports
        for (int a = 0; a < 16; a++) begin
            rd_addr = {4'(a), 4'(a)};
            #1;
            chk($sformatf("rst_rd0_a%0d", a), 32'(rdp(0, 0)), 32'h0);
            chk($sformatf("rst_rd1_a%0d", a), 32'(rdp(0, 1)), 32'h0);
        end
        chk("rst_drop", 32'(drop_w[0]), 32'h0);

        // Fill
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 16'(i * 16'h1111), 2'b11);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = {4'(15 - i), 4'(i)};
            #1;
            chk($sformatf("fill_p0_a%0d", i), 32'(rdp(0, 0)), 32'(i * 16'h1111));
            chk($sformatf("fill_p1_a%0d", 15 - i), 32'(rdp(0, 1)), 32'((15 - i) * 16'h1111));
        end

        // Byte enables
        do_write(4'd3, 16'hABCD, 2'b11);
        do_write(4'd3, 16'h1234, 2'b01);
        rd_addr = {4'd3, 4'd3};
        #1;
        chk("be_lo", 32'(rdp(0, 0)), 32'hAB34);
        do_write(4'd3, 16'hFFFF, 2'b00);
        #1;
        chk("be_none", 32'(rdp(0, 1)), 32'hAB34);
        do_write(4'd3, 16'h12EE, 2'b10);
        #1;
        chk("be_hi", 32'(rdp(0, 0)), 32'h1234);

        // Bypass / latency matrix on addr 7
        do_write(4'd7, 16'h0007, 2'b11);
        rd_addr = {4'd7, 4'd7};
        tick();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h5A5A; wr_be = 2'b11;
        #1;
        chk("byp_l0b1_p0", 32'(rdp(0, 0)), 32'h5A5A);
        chk("byp_l0b1_p1", 32'(rdp(0, 1)), 32'h5A5A);
        chk("byp_l0b0_pre", 32'(rdp(2, 0)), 32'h0007);
        chk("byp_l1b1_pre", 32'(rdp(1, 0)), 32'h0007);
        chk("byp_l1b0_pre", 32'(rdp(3, 1)), 32'h0007);
        chk("byp_drop_idle", 32'(drop_w[0]), 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("byp_l1b1_post", 32'(rdp(1, 1)), 32'h5A5A);
        chk("byp_l1b0_post", 32'(rdp(3, 0)), 32'h0007);
        chk("byp_l0b0_post", 32'(rdp(2, 1)), 32'h5A5A);
        tick();
        chk("byp_l1b0_late", 32'(rdp(3, 0)), 32'h5A5A);

        // Clear sweep with writes attempted throughout
        clr = 1'b1;
        #1;
        chk("clr_busy_before", 32'(busy_w[0]), 32'h0);
        tick();
        clr = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hBEEF; wr_be = 2'b11;
        busy_cnt = 0;
        drop_err = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!busy_w[0]) break;
            busy_cnt++;
            if (drop_w[0] !== 1'b1) drop_err++;
            tick();
        end
        wr_en = 1'b0;
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("clr_drop_all", 32'(drop_err), 32'd0);
        #1;
        chk("clr_drop_after", 32'(drop_w[0]), 32'h0);
        for (int a = 0; a < 16; a++) begin
            rd_addr = {4'(a), 4'(a)};
            #1;
            chk($sformatf("clr_zero_a%0d", a), 32'(rd_w[0]), 32'h0);
        end

        // Reset during sweep
        do_write(4'd9, 16'h9999, 2'b11);
        rd_addr = {4'd9, 4'd9};
        #1;
        chk("mid_pre", 32'(rdp(0, 0)), 32'h9999);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_busy", 32'(busy_w[0]), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_w[0]), 32'h0);
        chk("mid_rst_data", 32'(rdp(0, 0)), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_idle", 32'(busy_w[0]), 32'h0);
        do_write(4'd4, 16'h4444, 2'b11);
        rd_addr = {4'd9, 4'd4};
        #1;
        chk("mid_wr_ok", 32'(rdp(0, 0)), 32'h4444);
        chk("mid_a9_zero", 32'(rdp(0, 1)), 32'h0);

        // Zero register
        rd_addr = 8'h00;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
        #1;
        chk("zr_byp_p0", 32'(rdp(4, 0)), 32'h0);
        chk("zr_byp_p1", 32'(rdp(4, 1)), 32'h0);
        chk("zr_no_drop", 32'(drop_w[4]), 32'h0);
        chk("zr_ref_byp", 32'(rdp(0, 0)), 32'hFFFF);
        tick();
        wr_en = 1'b0;
        #1;
        chk("zr_post_p0", 32'(rdp(4, 0)), 32'h0);
        chk("zr_post_p1", 32'(rdp(4, 1)), 32'h0);
        chk("zr_ref_post", 32'(rdp(0, 1)), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
